secret_chk: RTL and testbench

Downstream result-checking stage for the per-cycle sample stream of the DPI test submodule. Each cycle the producer offers a (cycle value, task output) pair. The block buffers the pairs in a small FIFO and checks each one against the expected arithmetic relations. It counts samples and errors and signals pass or fail when the terminating cycle value arrives, so the top-level test can `$finish` on a single status bit.

---
 rtl/secret_chk.sv | 79 +++++++
 tb/tb_secret_chk.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/secret_chk.sv
// secret_chk: FIFO-buffered checker of (cyc, o) samples with sticky done/fail, sample/error counts and first failing cyc
module secret_chk #(
  parameter int DEPTH = 4,
  parameter int W = 32,
  parameter int STEP = 2,
  parameter int OFS = 1,
  parameter int END_CYC = 90
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_cyc,
  input  logic [W-1:0] in_o,
  input  logic         hold,
  output logic         done,
  output logic         fail,
  output logic [15:0]  sample_cnt,
  output logic [7:0]   err_cnt,
  output logic [W-1:0] first_err_cyc
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  localparam logic [W-1:0] STEP_W = W'(STEP);
  localparam logic [W-1:0] OFS_W = W'(OFS);
  localparam logic [W-1:0] END_W = W'(END_CYC);
  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;
  state_t state, state_d;
  logic [W-1:0] mem_cyc [DEPTH];
  logic [W-1:0] mem_o [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [W-1:0] prev, cyc, o;
  logic push, pop, err;
  assign in_ready = cnt != FULL;
  assign push = in_valid && in_ready;
  assign pop = state != DONE && cnt != '0 && !hold;
  assign cyc = mem_cyc[rp];
  assign o = mem_o[rp];
  assign err = o != cyc + OFS_W || (state == CHECK && cyc != prev + STEP_W);
  assign done = state == DONE;
  always_comb begin
    state_d = state;
    if (pop) state_d = cyc == END_W ? DONE : CHECK;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_cyc[wp] <= in_cyc;
      mem_o[wp] <= in_o;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      prev <= '0;
      sample_cnt <= '0;
      err_cnt <= '0;
      fail <= 1'b0;
      first_err_cyc <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (push) wp <= wp + AW'(1);
      if (pop) begin
        rp <= rp + AW'(1);
        prev <= cyc;
        if (sample_cnt != '1) sample_cnt <= sample_cnt + 16'd1;
        if (err) begin
          fail <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + 8'd1;
          if (err_cnt == '0) first_err_cyc <= cyc;
        end
      end
    end
  end
endmodule

// File: tb/tb_secret_chk.sv
// tb_secret_chk: scoreboard bench for secret_chk
module tb_secret_chk;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, hold = 1'b0;
  logic [31:0] in_cyc = '0, in_o = '0;
  logic in_ready, done, fail;
  logic [15:0] sample_cnt;
  logic [7:0] err_cnt;
  logic [31:0] first_err_cyc;
  int n_pass = 0, n_tot = 0;
  logic [63:0] sbq [$];
  logic m_idle = 1'b1, m_fail = 1'b0, m_done = 1'b0, r;
  logic [31:0] m_prev = '0, m_fec = '0;
  logic [15:0] m_sc = '0;
  logic [7:0] m_ec = '0;

  secret_chk dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_cyc(in_cyc), .in_o(in_o), .hold(hold), .done(done), .fail(fail),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt), .first_err_cyc(first_err_cyc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    logic [63:0] s;
    logic ok;
    r = rst;
    #2;
    if (!r && sample_cnt !== m_sc) begin
      n_tot++;
      if (sbq.size() == 0) $display("FAIL pop_empty: sample_cnt %0d with no sample pending", sample_cnt);
      else begin
        n_pass++;
        s = sbq.pop_front();
        ok = (s[31:0] == s[63:32] + 32'd1) && (m_idle || s[63:32] == m_prev + 32'd2);
        m_idle = 1'b0;
        m_prev = s[63:32];
        m_sc++;
        if (!ok) begin
          if (m_ec == 0) m_fec = s[63:32];
          if (m_ec != 8'hFF) m_ec++;
          m_fail = 1'b1;
        end
        if (s[63:32] == 32'd90) m_done = 1'b1;
        n_tot++; if (err_cnt !== m_ec) $display("FAIL sb_err_cnt cyc=%0d: got %0d want %0d", s[63:32], err_cnt, m_ec); else n_pass++;
        n_tot++; if (fail !== m_fail) $display("FAIL sb_fail cyc=%0d: got %0b want %0b", s[63:32], fail, m_fail); else n_pass++;
        n_tot++; if (first_err_cyc !== m_fec) $display("FAIL sb_first_err cyc=%0d: got %0d want %0d", s[63:32], first_err_cyc, m_fec); else n_pass++;
        n_tot++; if (done !== m_done) $display("FAIL sb_done cyc=%0d: got %0b want %0b", s[63:32], done, m_done); else n_pass++;
      end
    end
  end

  task automatic do_reset(input logic junk);
    rst = 1'b1; in_valid = junk; in_cyc = 32'd100; in_o = 32'd7; hold = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    sbq.delete();
    m_idle = 1'b1; m_fail = 1'b0; m_done = 1'b0; m_prev = '0; m_fec = '0; m_sc = '0; m_ec = '0;
  endtask

  task automatic send(input logic [31:0] c, input logic [31:0] o);
    int n = 0;
    in_cyc = c; in_o = o; in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      n_tot++;
      $display("FAIL send_timeout cyc=%0d: in_ready got 0 want 1", c);
    end else sbq.push_back({c, o});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_stream(input int skip, input int bad_o);
    for (int c = 0; c <= 90; c += 2)
      if (c != skip) send(c, c == bad_o ? 32'(c + 2) : 32'(c + 1));
  endtask

  task automatic test_reset;
    do_reset(1'b0);
    n_tot++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %0b want 1", in_ready); else n_pass++;
    n_tot++; if (done !== 1'b0) $display("FAIL rst_done: got %0b want 0", done); else n_pass++;
    n_tot++; if (fail !== 1'b0) $display("FAIL rst_fail: got %0b want 0", fail); else n_pass++;
    n_tot++; if (sample_cnt !== 16'd0) $display("FAIL rst_sample_cnt: got %0d want 0", sample_cnt); else n_pass++;
    n_tot++; if (err_cnt !== 8'd0) $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); else n_pass++;
    n_tot++; if (first_err_cyc !== 32'd0) $display("FAIL rst_first_err: got %0d want 0", first_err_cyc); else n_pass++;
  endtask

  task automatic test_clean;
    do_reset(1'b0);
    run_stream(-1, -1);
    n_tot++; if (done !== 1'b0) $display("FAIL clean_done_early: got %0b want 0", done); else n_pass++;
    @(posedge clk); #1;
    n_tot++; if (done !== 1'b1) $display("FAIL clean_done: got %0b want 1", done); else n_pass++;
    n_tot++; if (fail !== 1'b0) $display("FAIL clean_fail: got %0b want 0", fail); else n_pass++;
    n_tot++; if (sample_cnt !== 16'd46) $display("FAIL clean_sample_cnt: got %0d want 46", sample_cnt); else n_pass++;
    n_tot++; if (err_cnt !== 8'd0) $display("FAIL clean_err_cnt: got %0d want 0", err_cnt); else n_pass++;
  endtask

  task automatic test_offset_err;
    do_reset(1'b0);
    run_stream(-1, 10);
    repeat (2) @(posedge clk); #1;
    n_tot++; if (done !== 1'b1) $display("FAIL ofs_done: got %0b want 1", done); else n_pass++;
    n_tot++; if (fail !== 1'b1) $display("FAIL ofs_fail: got %0b want 1", fail); else n_pass++;
    n_tot++; if (err_cnt !== 8'd1) $display("FAIL ofs_err_cnt: got %0d want 1", err_cnt); else n_pass++;
    n_tot++; if (first_err_cyc !== 32'd10) $display("FAIL ofs_first_err: got %0d want 10", first_err_cyc); else n_pass++;
  endtask

  task automatic test_step_err;
    do_reset(1'b0);
    run_stream(20, 40);
    repeat (2) @(posedge clk); #1;
    n_tot++; if (err_cnt !== 8'd2) $display("FAIL step_err_cnt: got %0d want 2", err_cnt); else n_pass++;
    n_tot++; if (first_err_cyc !== 32'd22) $display("FAIL step_first_err: got %0d want 22", first_err_cyc); else n_pass++;
    n_tot++; if (sample_cnt !== 16'd45) $display("FAIL step_sample_cnt: got %0d want 45", sample_cnt); else n_pass++;
    n_tot++; if (done !== 1'b1) $display("FAIL step_done: got %0b want 1", done); else n_pass++;
  endtask

  task automatic test_backpressure;
    do_reset(1'b0);
    hold = 1'b1;
    for (int c = 0; c <= 6; c += 2) send(c, c + 1);
    n_tot++; if (in_ready !== 1'b0) $display("FAIL bp_full: in_ready got %0b want 0", in_ready); else n_pass++;
    in_cyc = 32'd8; in_o = 32'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    n_tot++; if (in_ready !== 1'b0) $display("FAIL bp_refused: in_ready got %0b want 0", in_ready); else n_pass++;
    n_tot++; if (sample_cnt !== 16'd0) $display("FAIL bp_hold: sample_cnt got %0d want 0", sample_cnt); else n_pass++;
    hold = 1'b0;
    @(posedge clk); #1;
    n_tot++; if (sample_cnt !== 16'd1) $display("FAIL bp_pop1: sample_cnt got %0d want 1", sample_cnt); else n_pass++;
    n_tot++; if (in_ready !== 1'b1) $display("FAIL bp_reopen: in_ready got %0b want 1", in_ready); else n_pass++;
    sbq.push_back({32'd8, 32'd9});
    for (int k = 2; k <= 5; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_tot++; if (sample_cnt !== 16'(k)) $display("FAIL bp_pop%0d: sample_cnt got %0d want %0d", k, sample_cnt, k); else n_pass++;
    end
    n_tot++; if (err_cnt !== 8'd0) $display("FAIL bp_err_cnt: got %0d want 0", err_cnt); else n_pass++;
  endtask

  task automatic test_wrap;
    do_reset(1'b0);
    send(32'hFFFF_FFFF, 32'd0);
    send(32'd1, 32'd2);
    @(posedge clk); #1;
    n_tot++; if (sample_cnt !== 16'd2) $display("FAIL wrap_sample_cnt: got %0d want 2", sample_cnt); else n_pass++;
    n_tot++; if (err_cnt !== 8'd0) $display("FAIL wrap_err_cnt: got %0d want 0", err_cnt); else n_pass++;
    n_tot++; if (fail !== 1'b0) $display("FAIL wrap_fail: got %0b want 0", fail); else n_pass++;
  endtask

  task automatic test_reset_mid;
    do_reset(1'b0);
    send(0, 1); send(2, 3); send(4, 0);
    @(posedge clk); #1;
    hold = 1'b1;
    send(6, 7); send(8, 9);
    n_tot++; if (sample_cnt !== 16'd3) $display("FAIL mid_pre_cnt: got %0d want 3", sample_cnt); else n_pass++;
    n_tot++; if (fail !== 1'b1) $display("FAIL mid_pre_fail: got %0b want 1", fail); else n_pass++;
    do_reset(1'b1);
    n_tot++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready: got %0b want 1", in_ready); else n_pass++;
    n_tot++; if (fail !== 1'b0) $display("FAIL mid_fail: got %0b want 0", fail); else n_pass++;
    n_tot++; if (err_cnt !== 8'd0) $display("FAIL mid_err_cnt: got %0d want 0", err_cnt); else n_pass++;
    n_tot++; if (sample_cnt !== 16'd0) $display("FAIL mid_sample_cnt: got %0d want 0", sample_cnt); else n_pass++;
    n_tot++; if (first_err_cyc !== 32'd0) $display("FAIL mid_first_err: got %0d want 0", first_err_cyc); else n_pass++;
    @(posedge clk); #1;
    n_tot++; if (sample_cnt !== 16'd0) $display("FAIL mid_discard: sample_cnt got %0d want 0", sample_cnt); else n_pass++;
    send(50, 51);
    @(posedge clk); #1;
    n_tot++; if (sample_cnt !== 16'd1) $display("FAIL mid_next_cnt: got %0d want 1", sample_cnt); else n_pass++;
    n_tot++; if (err_cnt !== 8'd0) $display("FAIL mid_next_err: got %0d want 0", err_cnt); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_clean;
    test_offset_err;
    test_step_err;
    test_backpressure;
    test_wrap;
    test_reset_mid;
    repeat (2) @(posedge clk); #3;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
